// File: rtl/traffic_light_sequencer.sv
// Two-road intersection light sequencer driven by the menu controller's durations and run state.
// Generates its own 1 s tick and exposes phase/seconds-left for the display path.
module traffic_light_sequencer #(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] green_duration,
    input  logic [7:0] yellow_duration,
    input  logic [7:0] red_holding,
    input  logic [1:0] sim_state,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [2:0] phase,
    output logic [7:0] seconds_left,
    output logic       sec_tick
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(TICKS_PER_SEC - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] NS_GREEN  = 3'd1;
    localparam logic [2:0] NS_YELLOW = 3'd2;
    localparam logic [2:0] ALL_RED_A = 3'd3;
    localparam logic [2:0] EW_GREEN  = 3'd4;
    localparam logic [2:0] EW_YELLOW = 3'd5;
    localparam logic [2:0] ALL_RED_B = 3'd6;
    localparam logic [2:0] ILLEGAL   = 3'd7;

    localparam logic [1:0] SIM_STOP = 2'd0;
    localparam logic [1:0] SIM_PLAY = 2'd1;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    logic [PW-1:0] prescaler;
    logic [PW-1:0] ps_nxt;
    logic [2:0]    phase_nxt;
    logic [7:0]    sl_nxt;
    logic          tick_nxt;

    // A zero duration still shows the phase for one full second.
    function automatic logic [7:0] eff(input logic [7:0] d);
        return (d == 8'd0) ? 8'd1 : d;
    endfunction

    function automatic logic [2:0] advance(input logic [2:0] ph);
        return (ph == ALL_RED_B) ? NS_GREEN : ph + 3'd1;
    endfunction

    function automatic logic [7:0] phase_duration(input logic [2:0] ph, input logic [7:0] g,
                                                  input logic [7:0] y, input logic [7:0] r);
        case (ph)
            NS_GREEN, EW_GREEN:   return g;
            NS_YELLOW, EW_YELLOW: return y;
            default:              return r;
        endcase
    endfunction

    function automatic logic [2:0] ns_lamp(input logic [2:0] ph);
        case (ph)
            NS_GREEN:  return LAMP_G;
            NS_YELLOW: return LAMP_Y;
            default:   return LAMP_R;
        endcase
    endfunction

    function automatic logic [2:0] ew_lamp(input logic [2:0] ph);
        case (ph)
            EW_GREEN:  return LAMP_G;
            EW_YELLOW: return LAMP_Y;
            default:   return LAMP_R;
        endcase
    endfunction

    always_comb begin
        phase_nxt = phase;
        sl_nxt    = seconds_left;
        ps_nxt    = prescaler;
        tick_nxt  = 1'b0;
        if (sim_state == SIM_STOP || phase == ILLEGAL) begin
            phase_nxt = IDLE;
            sl_nxt    = 8'd0;
            ps_nxt    = '0;
        end else if (sim_state == SIM_PLAY) begin
            if (phase == IDLE) begin
                phase_nxt = NS_GREEN;
                sl_nxt    = eff(green_duration);
                ps_nxt    = '0;
            end else if (prescaler == PS_MAX) begin
                ps_nxt   = '0;
                tick_nxt = 1'b1;
                if (seconds_left > 8'd1) begin
                    sl_nxt = seconds_left - 8'd1;
                end else begin
                    phase_nxt = advance(phase);
                    sl_nxt    = eff(phase_duration(phase_nxt, green_duration,
                                                   yellow_duration, red_holding));
                end
            end else begin
                ps_nxt = prescaler + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase        <= IDLE;
            seconds_left <= 8'd0;
            prescaler    <= '0;
            sec_tick     <= 1'b0;
        end else begin
            phase        <= phase_nxt;
            seconds_left <= sl_nxt;
            prescaler    <= ps_nxt;
            sec_tick     <= tick_nxt;
        end
    end

    // Lamps decode the next phase so they switch on the same edge as phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            ns_light <= LAMP_R;
            ew_light <= LAMP_R;
        end else begin
            ns_light <= ns_lamp(phase_nxt);
            ew_light <= ew_lamp(phase_nxt);
        end
    end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Scoreboard bench for traffic_light_sequencer with a 4-cycle second.
// Stimulus queues expected phase entries; a negedge monitor pops one per phase change.
module tb_traffic_light_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] green_duration;
    logic [7:0] yellow_duration;
    logic [7:0] red_holding;
    logic [1:0] sim_state;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [2:0] phase;
    logic [7:0] seconds_left;
    logic       sec_tick;

    traffic_light_sequencer #(.TICKS_PER_SEC(4)) dut (
        .clk(clk),
        .reset(reset),
        .green_duration(green_duration),
        .yellow_duration(yellow_duration),
        .red_holding(red_holding),
        .sim_state(sim_state),
        .ns_light(ns_light),
        .ew_light(ew_light),
        .phase(phase),
        .seconds_left(seconds_left),
        .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ph;
        int sl;
        int at;
        bit chk_sl;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_asserts = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    int   prev_ph = 0;
    int   t = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_asserts++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: actual %0d, required %0d", name, cyc, act, req);
        end
    endtask

    task automatic push(input int ph, input int sl, input int at);
        q.push_back('{ph, sl, at, 1'b1});
    endtask

    function automatic int exp_ns(input int ph);
        case (ph)
            1:       return 3'b001;
            2:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic int exp_ew(input int ph);
        case (ph)
            4:       return 3'b001;
            5:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    // Monitor: a phase change is the DUT presenting a new output record.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (int'(phase) != prev_ph) begin
                    if (q.size() == 0) begin
                        n_asserts++;
                        n_fail++;
                        $display("FAIL unexpected_entry at cycle %0d: actual phase %0d, required no entry",
                                 cyc, phase);
                    end else begin
                        e = q.pop_front();
                        check("entry_phase", int'(phase), e.ph);
                        check("entry_cycle", cyc, e.at);
                        if (e.chk_sl) check("entry_seconds", int'(seconds_left), e.sl);
                    end
                    prev_ph = int'(phase);
                end
                if (phase != 3'd7) begin
                    check("ns_lamp", int'(ns_light), exp_ns(int'(phase)));
                    check("ew_lamp", int'(ew_light), exp_ew(int'(phase)));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual cycle %0d, required finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        sim_state       = 2'd1;
        green_duration  = 8'd3;
        yellow_duration = 8'd2;
        red_holding     = 8'd1;
        repeat (3) step();
        check("reset_phase", int'(phase), 0);
        check("reset_seconds", int'(seconds_left), 0);
        check("reset_ns", int'(ns_light), 3'b100);
        check("reset_ew", int'(ew_light), 3'b100);
        check("reset_tick", int'(sec_tick), 0);
        prev_ph = int'(phase);
        mon_en  = 1'b1;

        // Full sequence with default durations.
        t = cyc;
        reset = 1'b0;
        push(1, 3, t + 1);  push(2, 2, t + 13); push(3, 1, t + 21);
        push(4, 3, t + 25); push(5, 2, t + 37); push(6, 1, t + 45);
        push(1, 3, t + 49);

        // Mid-phase green edit only affects later green entries.
        goto(t + 52);
        green_duration = 8'd5;
        push(2, 2, t + 61); push(3, 1, t + 69); push(4, 5, t + 73);
        push(5, 2, t + 93); push(6, 1, t + 101); push(1, 5, t + 105);

        // Pause with seconds_left=2, prescaler=2 inside NS_GREEN.
        goto(t + 119);
        check("pre_pause_seconds", int'(seconds_left), 2);
        sim_state = 2'd2;
        for (int i = 0; i < 20; i++) begin
            step();
            check("pause_phase", int'(phase), 1);
            check("pause_seconds", int'(seconds_left), 2);
            check("pause_tick", int'(sec_tick), 0);
        end
        sim_state = 2'd1;
        step();
        check("resume1_seconds", int'(seconds_left), 2);
        check("resume1_tick", int'(sec_tick), 0);
        step();
        check("resume2_seconds", int'(seconds_left), 1);
        check("resume2_tick", int'(sec_tick), 1);

        // Zero yellow behaves as one second.
        yellow_duration = 8'd0;
        push(2, 1, t + 145); push(3, 1, t + 149); push(4, 5, t + 153);
        push(5, 1, t + 173);

        // STOP mid EW_YELLOW.
        goto(t + 174);
        sim_state = 2'd0;
        push(0, 0, t + 175);
        goto(t + 178);
        sim_state = 2'd1;
        push(1, 5, t + 179); push(2, 1, t + 199); push(3, 1, t + 203);
        push(4, 5, t + 207); push(5, 1, t + 227); push(6, 1, t + 231);
        goto(t + 210);
        green_duration = 8'd3;

        // Reset pulse during ALL_RED_B while playing.
        goto(t + 232);
        reset = 1'b1;
        push(0, 0, t + 233); push(1, 3, t + 234);
        step();
        reset = 1'b0;

        // Illegal phase code recovers to IDLE.
        goto(t + 238);
        q.push_back('{7, 0, t + 238, 1'b0});
        push(0, 0, t + 239); push(1, 3, t + 240);
        force dut.phase = 3'd7;
        #1;
        release dut.phase;

        goto(t + 244);
        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
